// File: rtl/key_evt_pkg.sv
// ============================================================================
// Module      : key_evt_pkg
// Description : Shared types and constants for the key event scheduler:
//               FSM state encoding, drop counter width and the default
//               post-service lockout length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_evt_pkg;

  // Event port FSM: either waiting for a pending key or offering one.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } evt_state_e;

  // Width of the optional dropped-edge counter (saturates at all-ones).
  localparam int DROP_CNT_W = 8;

  // Lockout cycles applied to a key after it has been serviced.
  localparam int HOLDOFF_DEFAULT = 1000;

endpackage : key_evt_pkg

`default_nettype wire

// File: rtl/key_rr_pick.sv
// ============================================================================
// Module      : key_rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of pending_i, searching upward from ptr_i with wrap-around.
// Ports       : pending_i  - request vector
//               ptr_i      - search start index (must be < N_KEYS)
//               idx_o      - index of the selected request
//               found_o    - high when any request is set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_rr_pick #(
  parameter int N_KEYS = 4,
  parameter int IDX_W  = 2
) (
  input  logic [N_KEYS-1:0] pending_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              found_o
);

  // One extra bit so ptr + offset can exceed N_KEYS before the wrap.
  localparam int SW = IDX_W + 1;

  logic [SW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      cand = {1'b0, ptr_i} + SW'(k);
      if (cand >= SW'(N_KEYS)) begin
        cand = cand - SW'(N_KEYS);
      end
      if (!found_o && pending_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule : key_rr_pick

`default_nettype wire

// File: rtl/key_event_scheduler.sv
// ============================================================================
// Module      : key_event_scheduler
// Description : Turns rising edges on N_KEYS synchronous key levels into
//               queued events delivered one at a time over a valid/ready
//               port. Round-robin arbitration between pending keys and a
//               per-key lockout after service to swallow bounce.
// Ports       : clk          - system clock (rising edge)
//               rst_n        - asynchronous active-low reset
//               key_in       - key levels, synchronous to clk, active-high
//               evt_valid    - event offered
//               evt_id       - index of the offered key
//               evt_ready    - consumer accepts the offered event
//               evt_pending  - registered pending request vector
//               busy         - any request pending or event offered
//               drop_cnt     - saturating count of dropped edges
//                              (only when KEY_EVT_DROP_CNT_EN is defined)
// Config      : KEY_EVT_DROP_CNT_EN - adds the drop_cnt output
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter  int N_KEYS  = 4,
  parameter  int HOLDOFF = HOLDOFF_DEFAULT,
  parameter  int HOLD_W  = 16,
  localparam int IDX_W   = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic              evt_valid,
  output logic [IDX_W-1:0]  evt_id,
  input  logic              evt_ready,
  output logic [N_KEYS-1:0] evt_pending,
  output logic              busy
`ifdef KEY_EVT_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  evt_state_e        state_q;
  logic              evt_valid_q;
  logic [IDX_W-1:0]  evt_id_q;
  logic [IDX_W-1:0]  ptr_q;
  logic              busy_q;

  logic [N_KEYS-1:0] pending_q;
  logic [N_KEYS-1:0] pending_d;
  logic [N_KEYS-1:0] edge_w;
  logic [N_KEYS-1:0] locked_w;
  logic [N_KEYS-1:0] clear_w;

  logic              hs_w;
  logic              valid_d;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  // evt_valid_q is only ever high in OFFER, so this is the handshake.
  assign hs_w = evt_valid_q & evt_ready;

  // --------------------------------------------------------------------------
  // Per-key edge detector, pending latch and lockout counter
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic              prev_q;
    logic              pend_q;
    logic              pend_d;
    logic [HOLD_W-1:0] lock_q;

    assign edge_w[i]   = key_in[i] & ~prev_q;
    assign locked_w[i] = (lock_q != '0);
    assign clear_w[i]  = hs_w && (evt_id_q == IDX_W'(i));

    // Clearing on handshake takes priority, so an edge arriving in the
    // same cycle as this key's own handshake is lost.
    always_comb begin
      pend_d = pend_q;
      if (clear_w[i]) begin
        pend_d = 1'b0;
      end else if (edge_w[i] && !pend_q && !locked_w[i]) begin
        pend_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q <= 1'b0;
        pend_q <= 1'b0;
        lock_q <= '0;
      end else begin
        prev_q <= key_in[i];
        pend_q <= pend_d;
        if (clear_w[i]) begin
          lock_q <= HOLD_W'(HOLDOFF);
        end else if (locked_w[i]) begin
          lock_q <= lock_q - 1'b1;
        end
      end
    end

    assign pending_q[i] = pend_q;
    assign pending_d[i] = pend_d;
  end : g_key

  // --------------------------------------------------------------------------
  // Round-robin selection among pending keys
  // --------------------------------------------------------------------------
  key_rr_pick #(
    .N_KEYS (N_KEYS),
    .IDX_W  (IDX_W)
  ) u_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .idx_o     (pick_idx),
    .found_o   (pick_found)
  );

  // --------------------------------------------------------------------------
  // Event port FSM: offer is held stable until the consumer takes it
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            evt_id_q    <= pick_idx;
            evt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            evt_valid_q <= 1'b0;
            ptr_q       <= (evt_id_q == IDX_W'(N_KEYS - 1)) ? '0 : evt_id_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Next value of evt_valid, used only to register busy alongside it.
  always_comb begin
    valid_d = evt_valid_q;
    if (state_q == IDLE) begin
      valid_d = pick_found;
    end else if (evt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (|pending_d) | valid_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_id      = evt_id_q;
  assign evt_pending = pending_q;
  assign busy        = busy_q;

  // --------------------------------------------------------------------------
  // Optional dropped-edge counter
  // --------------------------------------------------------------------------
`ifdef KEY_EVT_DROP_CNT_EN
  localparam int CW = DROP_CNT_W + 1;

  logic [N_KEYS-1:0]     drop_w;
  logic [4:0]            drops_w;
  logic [CW-1:0]         drop_sum_w;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // A key is counted once even if several drop reasons coincide; the
  // handshake collision is always also a pending-set collision.
  assign drop_w = edge_w & (pending_q | locked_w | clear_w);

  always_comb begin
    drops_w = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      drops_w = drops_w + 5'(drop_w[k]);
    end
    drop_sum_w = {1'b0, drop_cnt_q} + CW'(drops_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_sum_w[CW-1]) begin
      drop_cnt_q <= '1;
    end else begin
      drop_cnt_q <= drop_sum_w[DROP_CNT_W-1:0];
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule : key_event_scheduler

`default_nettype wire

// File: tb/tb_key_event_scheduler.sv
// ============================================================================
// Module      : tb_key_event_scheduler
// Description : Directed self-checking bench for key_event_scheduler with
//               N_KEYS=4, HOLDOFF=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_event_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] evt_pending;
  logic       busy;
`ifdef KEY_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int tests;
  int fails;

  key_event_scheduler #(
    .N_KEYS  (4),
    .HOLDOFF (8),
    .HOLD_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .evt_pending (evt_pending),
    .busy        (busy)
`ifdef KEY_EVT_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then step off it so outputs are settled.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_in    = 4'b0000;
    evt_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    key_in    = 4'b0000;
    evt_ready = 1'b0;
    tick(2);
    tests++;
    if ({evt_valid, evt_id, evt_pending, busy} !== 8'b0) begin
      fails++;
      $display("FAIL reset_state: got valid=%0b id=%0d pend=%b busy=%0b, need all 0",
               evt_valid, evt_id, evt_pending, busy);
    end
`ifdef KEY_EVT_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_drop_cnt: got %0d need 0", drop_cnt);
    end
`endif
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single_key();
    do_reset();
    evt_ready = 1'b1;
    key_in    = 4'b0100;
    tick(1);  // sampling edge t
    tests++;
    if (evt_pending !== 4'b0100 || evt_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_edge_t: got pend=%b valid=%0b busy=%0b, need 0100/0/1",
               evt_pending, evt_valid, busy);
    end
    tick(1);  // t+1
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      fails++;
      $display("FAIL single_offer: got valid=%0b id=%0d, need 1/2", evt_valid, evt_id);
    end
    tick(1);  // t+2 handshake
    tests++;
    if (evt_valid !== 1'b0 || evt_pending !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_done: got valid=%0b pend=%b busy=%0b, need 0/0000/0",
               evt_valid, evt_pending, busy);
    end
    key_in = 4'b0000;
  endtask

  task automatic test_fairness();
    do_reset();
    evt_ready = 1'b1;
    key_in    = 4'b1011;
    tick(1);
    tests++;
    if (evt_pending !== 4'b1011) begin
      fails++;
      $display("FAIL fair_pending: got %b need 1011", evt_pending);
    end
    key_in = 4'b0000;
    tick(1);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      fails++;
      $display("FAIL fair_first: got valid=%0b id=%0d need 1/0", evt_valid, evt_id);
    end
    tick(1);
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL fair_gap: got valid=%0b need 0", evt_valid);
    end
    tick(1);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      fails++;
      $display("FAIL fair_second: got valid=%0b id=%0d need 1/1", evt_valid, evt_id);
    end
    tick(2);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      fails++;
      $display("FAIL fair_third: got valid=%0b id=%0d need 1/3", evt_valid, evt_id);
    end
    tick(1);
    tests++;
    if (evt_valid !== 1'b0 || evt_pending !== 4'b0000) begin
      fails++;
      $display("FAIL fair_drained: got valid=%0b pend=%b need 0/0000", evt_valid, evt_pending);
    end
    // Let lockouts expire, then service key 0 alone so the pointer sits at 1.
    tick(10);
    key_in = 4'b0001;
    tick(3);
    key_in = 4'b0000;
    tick(10);
    key_in = 4'b1001;
    tick(2);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      fails++;
      $display("FAIL fair_ptr1_first: got valid=%0b id=%0d need 1/3", evt_valid, evt_id);
    end
    key_in = 4'b0000;
    tick(2);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      fails++;
      $display("FAIL fair_ptr1_second: got valid=%0b id=%0d need 1/0", evt_valid, evt_id);
    end
    tick(1);
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    evt_ready = 1'b0;
    key_in    = 4'b0010;
    tick(2);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      fails++;
      $display("FAIL bp_offer: got valid=%0b id=%0d need 1/1", evt_valid, evt_id);
    end
    key_in = 4'b0001;
    tick(1);
    key_in = 4'b0000;
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      tick(1);
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: offer changed in %0d of 18 stalled cycles, need 0", bad);
    end
    tests++;
    if (evt_pending !== 4'b0011 || busy !== 1'b1) begin
      fails++;
      $display("FAIL bp_pending: got pend=%b busy=%0b need 0011/1", evt_pending, busy);
    end
    evt_ready = 1'b1;
    tick(1);
    tests++;
    if (evt_valid !== 1'b0 || evt_pending !== 4'b0001) begin
      fails++;
      $display("FAIL bp_release: got valid=%0b pend=%b need 0/0001", evt_valid, evt_pending);
    end
    tick(1);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      fails++;
      $display("FAIL bp_next: got valid=%0b id=%0d need 1/0", evt_valid, evt_id);
    end
    tick(1);
  endtask

  task automatic test_lockout();
    do_reset();
    evt_ready = 1'b1;
    key_in    = 4'b0100;
    tick(3);  // serviced at edge h
    key_in = 4'b0000;
    tick(4);  // h+1 .. h+4
    key_in = 4'b0100;
    tick(1);  // h+5: inside lockout
    tests++;
    if (evt_pending !== 4'b0000) begin
      fails++;
      $display("FAIL lock_drop: got pend=%b need 0000", evt_pending);
    end
`ifdef KEY_EVT_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL lock_drop_cnt: got %0d need 1", drop_cnt);
    end
`endif
    key_in = 4'b0000;
    tick(3);  // h+6 .. h+8
    key_in = 4'b0100;
    tick(1);  // h+9: lockout expired
    tests++;
    if (evt_pending !== 4'b0100) begin
      fails++;
      $display("FAIL lock_accept: got pend=%b need 0100", evt_pending);
    end
    key_in = 4'b0000;
    tick(1);
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      fails++;
      $display("FAIL lock_offer: got valid=%0b id=%0d need 1/2", evt_valid, evt_id);
    end
    tick(1);
  endtask

  task automatic test_collision();
    do_reset();
    evt_ready = 1'b0;
    key_in    = 4'b0010;
    tick(1);
    key_in = 4'b0000;
    tick(1);
    key_in = 4'b0010;  // second edge while pending is still set
    tick(1);
    key_in = 4'b0000;
`ifdef KEY_EVT_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL coll_pend_cnt: got %0d need 1", drop_cnt);
    end
`endif
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(2);
    tests++;
    if (evt_valid !== 1'b0 || evt_pending !== 4'b0000) begin
      fails++;
      $display("FAIL coll_single_event: got valid=%0b pend=%b need 0/0000", evt_valid, evt_pending);
    end
    tick(10);
    key_in = 4'b0010;
    tick(1);
    key_in = 4'b0000;
    tick(1);
    // Edge on key 1 lands on its own handshake edge.
    key_in    = 4'b0010;
    evt_ready = 1'b1;
    tick(1);
    key_in = 4'b0000;
    tick(1);
    tests++;
    if (evt_valid !== 1'b0 || evt_pending !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL coll_hs_drop: got valid=%0b pend=%b busy=%0b need 0/0000/0",
               evt_valid, evt_pending, busy);
    end
`ifdef KEY_EVT_DROP_CNT_EN
    tests++;
    if (drop_cnt !== 8'd2) begin
      fails++;
      $display("FAIL coll_hs_cnt: got %0d need 2", drop_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    evt_ready = 1'b0;
    key_in    = 4'b0100;
    tick(2);
    tests++;
    if (evt_valid !== 1'b1) begin
      fails++;
      $display("FAIL rmo_offer: got valid=%0b need 1", evt_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (evt_valid !== 1'b0 || evt_pending !== 4'b0000 || busy !== 1'b0 || evt_id !== 2'd0) begin
      fails++;
      $display("FAIL rmo_async: got valid=%0b pend=%b busy=%0b id=%0d need 0/0000/0/0",
               evt_valid, evt_pending, busy, evt_id);
    end
    key_in = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    tests++;
    if (evt_valid !== 1'b0 || evt_pending !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rmo_after: got valid=%0b pend=%b busy=%0b need 0/0000/0",
               evt_valid, evt_pending, busy);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    key_in    = 4'b0000;
    evt_ready = 1'b0;
    test_reset();
    test_single_key();
    test_fairness();
    test_backpressure();
    test_lockout();
    test_collision();
    test_reset_mid_offer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_key_event_scheduler

`default_nettype wire
